// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data RAM arbiter.
package cpu_mem_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        HOST_LOCK = 2'd1,
        RELEASE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PIPE = 2'd1,
        HOST = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// 4-bit up-counter that saturates at MAX; clear has priority over increment.
module arb_sat_counter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/data_ram_arbiter.sv
// Single-port data RAM arbiter: pipeline MEM stage has priority, host gets
// a starvation-forced slot and optional bounded locked bursts.
module data_ram_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEFAULT,
    parameter int unsigned HOST_MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [DATA_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [DATA_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [DATA_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    rd_owner_t        rd_owner_q;
    rd_owner_t        rd_owner_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             gnt_c;
    logic             force_grant;
    logic             lock_inc;
    logic             wait_inc;

    assign force_grant = (wait_cnt == CNT_W'(HOST_MAX_WAIT));

    // Grant decision and next state; the granting ARB cycle is the first locked cycle.
    always_comb begin
        state_d = state_q;
        gnt_c   = 1'b0;
        unique case (state_q)
            ARB: begin
                gnt_c = host_req && (!pipe_req || force_grant);
                if (gnt_c && host_lock) begin
                    state_d = (LOCK_MAX == 1) ? RELEASE : HOST_LOCK;
                end
            end
            HOST_LOCK: begin
                gnt_c = host_req;
                if (!host_req || !host_lock) begin
                    state_d = ARB;
                end else if (lock_cnt >= CNT_W'(LOCK_MAX - 1)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
        if (!reset) begin
            gnt_c = 1'b0;
        end
    end

    always_comb begin
        rd_owner_d = NONE;
        if (gnt_c && !host_we) begin
            rd_owner_d = HOST;
        end else if (pipe_req && !pipe_we && !gnt_c) begin
            rd_owner_d = PIPE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB;
            rd_owner_q <= NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign wait_inc = host_req && !gnt_c;
    assign lock_inc = gnt_c && host_lock;

    arb_sat_counter #(
        .MAX (HOST_MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (!wait_inc),
        .inc_i (wait_inc),
        .cnt_o (wait_cnt)
    );

    arb_sat_counter #(
        .MAX (15)
    ) u_lock_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (!lock_inc),
        .inc_i (lock_inc),
        .cnt_o (lock_cnt)
    );

    // Outputs held at zero while reset is asserted.
    assign host_gnt    = gnt_c;
    assign pipe_stall  = pipe_req && gnt_c;
    assign ram_address = !reset ? '0 : (gnt_c ? host_addr : pipe_addr);
    assign ram_data    = !reset ? '0 : (gnt_c ? host_wdata : pipe_wdata);
    assign ram_wren    = reset && (gnt_c ? host_we : (pipe_req && pipe_we));
    assign host_rvalid = (rd_owner_q == HOST);
    assign host_rdata  = reset ? ram_q : '0;
    assign pipe_rdata  = reset ? ram_q : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized and directed bench for data_ram_arbiter against a burst/refusal-count model.
module tb_data_ram_arbiter;

    localparam int unsigned HMW = 4;
    localparam int unsigned LM  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_we, pipe_stall;
    logic [15:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic [15:0] ram_address, ram_data, ram_q;
    logic        ram_wren;

    logic [15:0] ram_mem [256];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [15:0] ref_mem [256];
    int          m_refused;
    int          m_burst;
    bit          m_cool;
    int          m_rd;
    logic [15:0] m_rd_data;
    bit          last_gnt;
    bit          last_stall;

    // stimulus shadow
    logic        d_preq, d_pwe, d_hreq, d_hwe, d_hlock;
    logic [15:0] d_paddr, d_pwdata, d_haddr, d_hwdata;

    bit g_obs [20];
    bit s_obs [20];

    data_ram_arbiter #(
        .DATA_W        (16),
        .HOST_MAX_WAIT (HMW),
        .LOCK_MAX      (LM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_req    (pipe_req),
        .pipe_we     (pipe_we),
        .pipe_addr   (pipe_addr),
        .pipe_wdata  (pipe_wdata),
        .pipe_rdata  (pipe_rdata),
        .pipe_stall  (pipe_stall),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    // external single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
        ram_q <= ram_mem[ram_address[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        pipe_req   = d_preq;
        pipe_we    = d_pwe;
        pipe_addr  = d_paddr;
        pipe_wdata = d_pwdata;
        host_req   = d_hreq;
        host_we    = d_hwe;
        host_lock  = d_hlock;
        host_addr  = d_haddr;
        host_wdata = d_hwdata;
    endtask

    task automatic idle_inputs();
        d_preq = 0; d_pwe = 0; d_paddr = '0; d_pwdata = '0;
        d_hreq = 0; d_hwe = 0; d_hlock = 0; d_haddr = '0; d_hwdata = '0;
    endtask

    task automatic model_reset();
        m_refused = 0; m_burst = 0; m_cool = 0; m_rd = 0; m_rd_data = '0;
        last_gnt = 0; last_stall = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"},    32'(host_gnt),    32'(0));
        check_eq({tag, "_stall"},  32'(pipe_stall),  32'(0));
        check_eq({tag, "_wren"},   32'(ram_wren),    32'(0));
        check_eq({tag, "_addr"},   32'(ram_address), 32'(0));
        check_eq({tag, "_data"},   32'(ram_data),    32'(0));
        check_eq({tag, "_rvalid"}, 32'(host_rvalid), 32'(0));
        check_eq({tag, "_hrdata"}, 32'(host_rdata),  32'(0));
        check_eq({tag, "_prdata"}, 32'(pipe_rdata),  32'(0));
    endtask

    // One clock: apply shadow inputs, compare DUT to model, advance model.
    task automatic cycle();
        bit          e_gnt, e_stall, e_wren;
        logic [15:0] e_addr, e_data;
        @(negedge clk);
        apply();
        #1;
        if (m_cool)           e_gnt = 0;
        else if (m_burst > 0) e_gnt = d_hreq;
        else                  e_gnt = d_hreq && (!d_preq || m_refused >= int'(HMW));
        e_stall = d_preq && e_gnt;
        e_wren  = e_gnt ? d_hwe : (d_preq && d_pwe);
        e_addr  = e_gnt ? d_haddr : d_paddr;
        e_data  = e_gnt ? d_hwdata : d_pwdata;

        check_eq("host_gnt",    32'(host_gnt),    32'(e_gnt));
        check_eq("pipe_stall",  32'(pipe_stall),  32'(e_stall));
        check_eq("ram_wren",    32'(ram_wren),    32'(e_wren));
        check_eq("ram_address", 32'(ram_address), 32'(e_addr));
        check_eq("ram_data",    32'(ram_data),    32'(e_data));
        check_eq("host_rvalid", 32'(host_rvalid), 32'(m_rd == 2));
        if (m_rd == 2) check_eq("host_rdata", 32'(host_rdata), 32'(m_rd_data));
        if (m_rd == 1) check_eq("pipe_rdata", 32'(pipe_rdata), 32'(m_rd_data));

        if (e_gnt && !d_hwe) begin
            m_rd = 2; m_rd_data = ref_mem[d_haddr[7:0]];
        end else if (d_preq && !d_pwe && !e_gnt) begin
            m_rd = 1; m_rd_data = ref_mem[d_paddr[7:0]];
        end else begin
            m_rd = 0;
        end
        if (e_wren) ref_mem[e_addr[7:0]] = e_data;

        if (d_hreq && !e_gnt) m_refused = (m_refused < int'(HMW)) ? m_refused + 1 : m_refused;
        else                  m_refused = 0;

        if (m_cool) begin
            m_cool = 0; m_burst = 0;
        end else if (e_gnt && d_hlock) begin
            m_burst++;
            if (m_burst >= int'(LM)) begin
                m_cool = 1; m_burst = 0;
            end
        end else begin
            m_burst = 0;
        end
        last_gnt   = e_gnt;
        last_stall = e_stall;
    endtask

    initial begin
        int run;
        int first;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();
        reset = 1'b0;
        // requests during reset must not reach the outputs
        d_preq = 1; d_pwe = 1; d_paddr = 16'h0005; d_pwdata = 16'h00FF;
        d_hreq = 1; d_hwe = 1; d_hlock = 1; d_haddr = 16'h0006; d_hwdata = 16'h0077;
        apply();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        idle_inputs();
        apply();
        reset = 1'b1;

        // preload the small address window through the pipe port
        for (int a = 0; a < 16; a++) begin
            idle_inputs();
            d_preq = 1; d_pwe = 1; d_paddr = 16'(a); d_pwdata = 16'(a * 16'h1111);
            cycle();
        end

        // pipe only: write then read back
        idle_inputs();
        d_preq = 1; d_pwe = 1; d_paddr = 16'h0010; d_pwdata = 16'hBEEF;
        cycle();
        check_eq("pipe_wr_stall", 32'(pipe_stall), 32'(0));
        d_pwe = 0;
        cycle();
        check_eq("pipe_rd_stall", 32'(pipe_stall), 32'(0));
        idle_inputs();
        cycle();
        check_eq("pipe_rd_data", 32'(pipe_rdata), 32'(16'hBEEF));

        // host only: write then read back
        idle_inputs();
        d_hreq = 1; d_hwe = 1; d_haddr = 16'h0020; d_hwdata = 16'h1234;
        cycle();
        check_eq("host_wr_gnt", 32'(host_gnt), 32'(1));
        d_hwe = 0;
        cycle();
        check_eq("host_rd_gnt", 32'(host_gnt), 32'(1));
        idle_inputs();
        cycle();
        check_eq("host_rd_valid", 32'(host_rvalid), 32'(1));
        check_eq("host_rd_data",  32'(host_rdata),  32'(16'h1234));

        // starvation: forced grant every HMW+1 cycles
        idle_inputs();
        d_preq = 1; d_pwe = 0; d_paddr = 16'h0003;
        d_hreq = 1; d_hwe = 1; d_haddr = 16'h0005; d_hwdata = 16'hA5A5;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("starve_gnt",   32'(host_gnt),   32'((i % 5) == 4));
            check_eq("starve_stall", 32'(pipe_stall), 32'((i % 5) == 4));
        end
        idle_inputs();
        cycle();

        // locked burst under continuous pipe traffic
        d_preq = 1; d_pwe = 0; d_paddr = 16'h0007;
        d_hreq = 1; d_hwe = 0; d_hlock = 1; d_haddr = 16'h0009;
        for (int i = 0; i < 20; i++) begin
            cycle();
            g_obs[i] = host_gnt;
            s_obs[i] = pipe_stall;
        end
        first = 20;
        for (int i = 19; i >= 0; i--) if (g_obs[i]) first = i;
        run = 0;
        for (int i = first; i < 20 && g_obs[i]; i++) run++;
        check_eq("lock_first", 32'(first), 32'(HMW));
        check_eq("lock_run", 32'(run), 32'(LM));
        if (first + run < 20) begin
            check_eq("lock_release_stall", 32'(s_obs[first + run]), 32'(0));
        end
        run = 0;
        for (int i = first + int'(LM) + 1; i < 20; i++) if (g_obs[i]) run++;
        check_eq("lock_regrant", 32'(run > 0), 32'(1));
        idle_inputs();
        cycle();

        // reset arriving just before the edge that would return a host read
        d_hreq = 1; d_hwe = 0; d_hlock = 1; d_haddr = 16'h0020;
        cycle();
        check_eq("rstrd_gnt", 32'(host_gnt), 32'(1));
        #3;
        reset = 1'b0;
        model_reset();
        #2;
        check_all_zero("rstrd_a");
        @(negedge clk);
        #1;
        check_all_zero("rstrd_b");
        @(negedge clk);
        idle_inputs();
        apply();
        reset = 1'b1;
        d_preq = 1; d_pwe = 0; d_paddr = 16'h0002;
        d_hreq = 1; d_hwe = 0; d_hlock = 1; d_haddr = 16'h0004;
        cycle();
        check_eq("post_rst_gnt", 32'(host_gnt), 32'(0));
        idle_inputs();
        cycle();

        // randomized traffic; stalled pipe accesses are re-presented unchanged
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                d_preq   = ($urandom_range(0, 3) != 0);
                d_pwe    = 1'($urandom_range(0, 1));
                d_paddr  = 16'($urandom_range(0, 15));
                d_pwdata = 16'($urandom);
            end
            if (!d_hreq || last_gnt) begin
                d_hreq   = ($urandom_range(0, 2) != 0);
                d_hwe    = 1'($urandom_range(0, 1));
                d_haddr  = 16'($urandom_range(0, 15));
                d_hwdata = 16'($urandom);
            end
            d_hlock = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port data RAM between the pipeline's Memory stage and a host/loader port. The pipeline has priority. A starvation counter guarantees the host a slot. A lock mode gives the host bounded bursts, and the pipeline is stalled whenever it loses the RAM. The block sits between the ExecuteMemory register outputs, the MemoryWriteback register input and the RAM instance.

## Interface
- `DATA_W`, 16: address and data width.
- `HOST_MAX_WAIT`, 4: number of cycles the host may be refused before a forced grant. Legal range 1..15.
- `LOCK_MAX`, 8: maximum consecutive locked host cycles before a forced release. Legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pipe_req`  in  1  MEM stage requests an access this cycle.
- `pipe_we`  in  1  MEM stage write enable.
- `pipe_addr`  in  DATA_W  MEM stage address.
- `pipe_wdata`  in  DATA_W  MEM stage write data.
- `pipe_rdata`  out  DATA_W  read data to the MEM/WB register.
- `pipe_stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers this cycle.
- `host_req`  in  1  host requests an access.
- `host_we`  in  1  host write enable.
- `host_lock`  in  1  host asks to keep the grant on following cycles.
- `host_addr`  in  DATA_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_gnt`  out  1  host access accepted this cycle.
- `host_rvalid`  out  1  host read data valid.
- `host_rdata`  out  DATA_W  host read data.
- `ram_address`  out  DATA_W  to RAM `address`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_q`  in  DATA_W  from RAM `q`; data appears 1 cycle after the address.

## Operation
- **FSM states:** ARB, HOST_LOCK, RELEASE. Reset state is ARB.
- **ARB:**
  - `force = (wait_cnt == HOST_MAX_WAIT)`.
  - `host_gnt = host_req && (!pipe_req || force)`.
  - Go to HOST_LOCK when `host_gnt && host_lock`.
- **HOST_LOCK:**
  - `host_gnt = host_req`.
  - `lock_cnt` increments on each locked cycle.
  - Go to ARB when `!host_req || !host_lock`.
  - Go to RELEASE when `lock_cnt == LOCK_MAX-1` and the lock is still held.
- **RELEASE:** one cycle.
  - `host_gnt = 0`; the pipeline owns the RAM.
  - Go to ARB.
- **Stall:** `pipe_stall = pipe_req && host_gnt`. A stalled pipe access is re-presented unchanged next cycle.
- **RAM mux:** when `host_gnt`, drive host address/data/we onto the RAM; otherwise drive the pipe signals. `ram_wren = (host_gnt ? host_we : pipe_req && pipe_we)`.
- **wait_cnt:**
  - Increments when `host_req && !host_gnt`; saturates at HOST_MAX_WAIT.
  - Clears on `host_gnt` or `!host_req`.
  - After a forced grant the pipeline therefore gets at least HOST_MAX_WAIT cycles before the next force.
- **Read return:** `rd_owner` register captures `{host read, pipe read, none}` each cycle.
  - `host_rvalid` is 1 the cycle after a granted host read.
  - `host_rdata = pipe_rdata = ram_q`, unmasked; consumers qualify with valid/owner.
- **Lock length:** `lock_cnt` clears in ARB. `host_lock` without `host_req` is ignored.
- **Simultaneous requests:** exactly one owner per cycle, so there is no write collision. Host write and pipe read in the same cycle gives host write, pipe stalled.

## Timing
- **Reset values:** all outputs 0, `wait_cnt` = 0, `lock_cnt` = 0, state ARB, `rd_owner` none.
- **Reset mid-operation:** an in-flight read's `host_rvalid` is suppressed; the lock is dropped.
- **Combinational paths:** `host_gnt`, `pipe_stall` and the RAM mux are combinational from requests and registered state, with zero added latency.
- **Read latency:** 1 cycle, equal to the RAM's.
- **Worst-case host wait:** HOST_MAX_WAIT cycles under continuous `pipe_req`.
- **Worst-case pipe stall:** LOCK_MAX consecutive cycles, then 1 guaranteed pipe cycle.

## Structure
- Package `cpu_mem_pkg` holds:
  - `arb_state_t` (ARB, HOST_LOCK, RELEASE);
  - `rd_owner_t` (NONE, PIPE, HOST);
  - the `DATA_W` default constant.
- One sub-module, `arb_sat_counter`: a 4-bit saturating counter with clear, used for both `wait_cnt` and `lock_cnt`.

## Test plan
- **Pipe only:** `pipe_req=1`, `pipe_we=1`, addr 0x0010, data 0xBEEF, then a read of 0x0010. Expect `pipe_stall=0` throughout and `pipe_rdata=0xBEEF` one cycle after the read.
- **Host only:** host write 0x0020←0x1234, then host read. Expect `host_gnt=1` both cycles, and `host_rvalid=1` with `host_rdata=0x1234` on the following cycle.
- **Starvation:** continuous `pipe_req` with `host_req`, HOST_MAX_WAIT=4. Expect `host_gnt=0` for 4 cycles and `host_gnt=1`, `pipe_stall=1` on cycle 5. The next forced grant comes no earlier than 4 further cycles.
- **Lock:** `host_lock=1`, LOCK_MAX=8, `pipe_req=1`. Expect 8 consecutive grants, then a RELEASE cycle with `pipe_stall=0`, then the host is re-granted.
- **Reset mid-read:** host read granted, `reset` low in the next cycle. Expect `host_rvalid` to stay 0, all outputs 0, and the state to be ARB after release.
